// File: rtl/mem_lsu_if.sv
// Data-RAM request/acknowledge bus between the MEM-stage load/store unit and memory.
// The master issues word-addressed accesses; the slave completes them with d_ack.
interface mem_lsu_if;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [3:0]  d_be;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;

   modport master (
      output d_req, d_we, d_addr, d_be, d_wdata,
      input  d_ack, d_rdata
   );

   modport slave (
      input  d_req, d_we, d_addr, d_be, d_wdata,
      output d_ack, d_rdata
   );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues req/ack data-RAM accesses, aligns and extends
// load data, stalls the pipeline while busy, flags misaligned addresses and bus timeouts.
module mem_lsu #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  mem_op,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        mem_reg_wr,
   output logic [31:0] lsu_rdata,
   output logic        lsu_reg_wr,
   output logic        stall_req,
   output logic        addr_err,
   output logic        bus_err,
   mem_lsu_if.master   dbus
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

   state_t             state, state_nxt;
   logic               is_load, is_store, is_signed, valid, misaligned, go, timeout;
   size_t              size;
   logic [3:0]         be_nxt;
   logic [31:0]        wd_nxt;
   logic [CNT_W-1:0]   cnt;
   logic               ld_q, sgn_q;
   size_t              size_q;
   logic [1:0]         off_q;
   logic [31:0]        lane;
   logic [31:0]        load_data;

   always_comb begin
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_signed = 1'b0;
      size      = SZ_W;
      case (mem_op)
         4'h1: begin is_load  = 1'b1; is_signed = 1'b1; size = SZ_B; end
         4'h2: begin is_load  = 1'b1; size = SZ_B; end
         4'h3: begin is_load  = 1'b1; is_signed = 1'b1; size = SZ_H; end
         4'h4: begin is_load  = 1'b1; size = SZ_H; end
         4'h5: begin is_load  = 1'b1; size = SZ_W; end
         4'h9: begin is_store = 1'b1; size = SZ_B; end
         4'hA: begin is_store = 1'b1; size = SZ_H; end
         4'hB: begin is_store = 1'b1; size = SZ_W; end
         default: ;
      endcase
   end

   assign valid      = is_load | is_store;
   assign misaligned = ((size == SZ_H) & mem_addr[0]) | ((size == SZ_W) & (|mem_addr[1:0]));
   assign go         = (state == IDLE) & valid & ~misaligned;
   assign timeout    = (cnt == CNT_W'(TIMEOUT - 1));

   always_comb begin
      be_nxt = 4'b1111;
      wd_nxt = mem_wdata;
      case (size)
         SZ_B: begin
            be_nxt = 4'b0001 << mem_addr[1:0];
            wd_nxt = {4{mem_wdata[7:0]}};
         end
         SZ_H: begin
            be_nxt = 4'b0011 << mem_addr[1:0];
            wd_nxt = {2{mem_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign lane = dbus.d_rdata >> {off_q, 3'b000};

   always_comb begin
      load_data = dbus.d_rdata;
      case (size_q)
         SZ_B:    load_data = {{24{sgn_q & lane[7]}},  lane[7:0]};
         SZ_H:    load_data = {{16{sgn_q & lane[15]}}, lane[15:0]};
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (go) state_nxt = REQ;
         REQ:     if (dbus.d_ack || timeout) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // rst gates the combinational strobes so reset silences them even with a live mem_op
   always_comb begin
      stall_req  = 1'b0;
      addr_err   = 1'b0;
      lsu_reg_wr = 1'b0;
      case (state)
         IDLE: begin
            if (!valid)          lsu_reg_wr = mem_reg_wr;
            else if (misaligned) addr_err   = ~rst;
            else                 stall_req  = ~rst;
         end
         REQ:     stall_req  = 1'b1;
         DONE:    lsu_reg_wr = mem_reg_wr & ld_q & ~bus_err;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbus.d_req   <= 1'b0;
         dbus.d_we    <= 1'b0;
         dbus.d_addr  <= '0;
         dbus.d_be    <= '0;
         dbus.d_wdata <= '0;
         lsu_rdata    <= '0;
         bus_err      <= 1'b0;
         cnt          <= '0;
         ld_q         <= 1'b0;
         sgn_q        <= 1'b0;
         size_q       <= SZ_W;
         off_q        <= '0;
      end else begin
         bus_err <= 1'b0;
         case (state)
            IDLE: begin
               if (go) begin
                  dbus.d_req   <= 1'b1;
                  dbus.d_we    <= is_store;
                  dbus.d_addr  <= {mem_addr[31:2], 2'b00};
                  dbus.d_be    <= be_nxt;
                  dbus.d_wdata <= wd_nxt;
                  cnt          <= '0;
                  ld_q         <= is_load;
                  sgn_q        <= is_signed;
                  size_q       <= size;
                  off_q        <= mem_addr[1:0];
               end
            end
            REQ: begin
               if (dbus.d_ack) begin
                  if (ld_q) lsu_rdata <= load_data;
                  dbus.d_req <= 1'b0;
                  dbus.d_we  <= 1'b0;
               end else if (timeout) begin
                  dbus.d_req <= 1'b0;
                  dbus.d_we  <= 1'b0;
                  lsu_rdata  <= '0;
                  bus_err    <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed cases plus randomized accesses checked
// against a byte-lane reference model of loads, stores, alignment and timeouts.
module tb_mem_lsu;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  mem_op;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_reg_wr;
   logic [31:0] lsu_rdata;
   logic        lsu_reg_wr;
   logic        stall_req;
   logic        addr_err;
   logic        bus_err;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_rdata = '0;

   mem_lsu_if bus ();

   mem_lsu #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_op     (mem_op),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_reg_wr (mem_reg_wr),
      .lsu_rdata  (lsu_rdata),
      .lsu_reg_wr (lsu_reg_wr),
      .stall_req  (stall_req),
      .addr_err   (addr_err),
      .bus_err    (bus_err),
      .dbus       (bus)
   );

   always #5 clk = ~clk;

   // 0 = no access, 1 = load, 2 = store
   function automatic int kind_of(input logic [3:0] op);
      case (op)
         4'h1, 4'h2, 4'h3, 4'h4, 4'h5: return 1;
         4'h9, 4'hA, 4'hB:             return 2;
         default:                      return 0;
      endcase
   endfunction

   function automatic int nbytes(input logic [3:0] op);
      case (op)
         4'h1, 4'h2, 4'h9: return 1;
         4'h3, 4'h4, 4'hA: return 2;
         default:          return 4;
      endcase
   endfunction

   function automatic logic [3:0] exp_be(input int n, input int off);
      int v;
      if (n == 4) return 4'hF;
      v = ((1 << n) - 1) << off;
      return v[3:0];
   endfunction

   function automatic logic [31:0] exp_wd(input int n, input logic [31:0] wd);
      if (n == 1) return {24'h0, wd[7:0]} * 32'h01010101;
      if (n == 2) return {16'h0, wd[15:0]} * 32'h00010001;
      return wd;
   endfunction

   function automatic logic [31:0] exp_ld(input logic [3:0] op, input int n, input int off,
                                          input logic [31:0] rd);
      logic [31:0] mask, v;
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      v = (rd >> (8 * off)) & mask;
      if ((op == 4'h1 || op == 4'h3) && v[8 * n - 1]) v = v | ~mask;
      return v;
   endfunction

   // Starts and ends at a falling edge with the DUT idle.
   task automatic run_access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                             input logic rw, input int ack_delay, input logic [31:0] rd);
      int kind, n, off, req_n, exp_req;
      logic mis, tout;
      logic [31:0] e_addr, e_wd;
      logic [3:0] e_be;
      kind = kind_of(op);
      n    = nbytes(op);
      off  = int'(addr[1:0]);
      mis  = (kind != 0) && ((off % n) != 0);
      mem_op = op; mem_addr = addr; mem_wdata = wd; mem_reg_wr = rw;
      bus.d_ack = (kind == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.d_rdata = $urandom;
      #1;
      if (kind == 0 || mis) begin
         checks++;
         if (stall_req !== 1'b0) begin errors++; $display("FAIL idle_stall op=%h a=%h: got %b expected 0", op, addr, stall_req); end
         checks++;
         if (addr_err !== mis) begin errors++; $display("FAIL addr_err op=%h a=%h: got %b expected %b", op, addr, addr_err, mis); end
         checks++;
         if (lsu_reg_wr !== ((kind == 0) ? rw : 1'b0)) begin errors++; $display("FAIL idle_reg_wr op=%h a=%h: got %b expected %b", op, addr, lsu_reg_wr, (kind == 0) ? rw : 1'b0); end
         @(posedge clk); @(negedge clk);
         checks++;
         if (bus.d_req !== 1'b0) begin errors++; $display("FAIL no_req op=%h a=%h: got d_req=%b expected 0", op, addr, bus.d_req); end
         checks++;
         if (lsu_rdata !== exp_rdata) begin errors++; $display("FAIL rdata_hold op=%h: got %h expected %h", op, lsu_rdata, exp_rdata); end
         mem_op = 4'h0;
         bus.d_ack = 1'b0;
         return;
      end
      e_addr = {addr[31:2], 2'b00};
      e_be   = exp_be(n, off);
      e_wd   = exp_wd(n, wd);
      checks++;
      if ({stall_req, addr_err, bus.d_req} !== 3'b100) begin errors++; $display("FAIL start op=%h a=%h: got stall,addr_err,d_req=%b expected 100", op, addr, {stall_req, addr_err, bus.d_req}); end
      req_n = 0;
      @(posedge clk); @(negedge clk);
      while (stall_req === 1'b1 && req_n < 40) begin
         checks++;
         if ({bus.d_req, bus.d_we} !== {1'b1, kind == 2}) begin errors++; $display("FAIL req_we op=%h cyc=%0d: got %b expected %b", op, req_n, {bus.d_req, bus.d_we}, {1'b1, kind == 2}); end
         checks++;
         if (bus.d_addr !== e_addr || bus.d_be !== e_be || bus.d_wdata !== e_wd) begin
            errors++;
            $display("FAIL bus_fields op=%h cyc=%0d: got addr=%h be=%b wd=%h expected addr=%h be=%b wd=%h", op, req_n, bus.d_addr, bus.d_be, bus.d_wdata, e_addr, e_be, e_wd);
         end
         bus.d_ack   = (req_n == ack_delay);
         bus.d_rdata = (req_n == ack_delay) ? rd : $urandom;
         req_n++;
         @(posedge clk); @(negedge clk);
      end
      bus.d_ack = 1'b0;
      tout    = !(ack_delay >= 0 && ack_delay < TIMEOUT);
      exp_req = tout ? TIMEOUT : ack_delay + 1;
      if (tout) exp_rdata = '0;
      else if (kind == 1) exp_rdata = exp_ld(op, n, off, rd);
      checks++;
      if (req_n !== exp_req) begin errors++; $display("FAIL req_cycles op=%h: got %0d expected %0d", op, req_n, exp_req); end
      checks++;
      if ({stall_req, bus.d_req, bus.d_we} !== 3'b000) begin errors++; $display("FAIL done_idle op=%h: got stall,d_req,d_we=%b expected 000", op, {stall_req, bus.d_req, bus.d_we}); end
      checks++;
      if (bus_err !== tout) begin errors++; $display("FAIL bus_err op=%h: got %b expected %b", op, bus_err, tout); end
      checks++;
      if (lsu_reg_wr !== (rw && kind == 1 && !tout)) begin errors++; $display("FAIL done_reg_wr op=%h: got %b expected %b", op, lsu_reg_wr, rw && kind == 1 && !tout); end
      checks++;
      if (lsu_rdata !== exp_rdata) begin errors++; $display("FAIL lsu_rdata op=%h a=%h rd=%h: got %h expected %h", op, addr, rd, lsu_rdata, exp_rdata); end
      mem_op = 4'h0;
      @(posedge clk); @(negedge clk);
      checks++;
      if ({bus_err, stall_req} !== 2'b00) begin errors++; $display("FAIL after_done op=%h: got bus_err,stall=%b expected 00", op, {bus_err, stall_req}); end
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_op = 4'h0; mem_addr = '0; mem_wdata = '0; mem_reg_wr = 1'b0;
      bus.d_ack = 1'b0; bus.d_rdata = '0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({bus.d_req, bus.d_we, stall_req, addr_err, bus_err} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {bus.d_req, bus.d_we, stall_req, addr_err, bus_err}); end
      checks++;
      if (bus.d_be !== 4'h0) begin errors++; $display("FAIL reset_be: got %b expected 0000", bus.d_be); end
      checks++;
      if ({lsu_rdata, bus.d_addr, bus.d_wdata} !== 96'h0) begin errors++; $display("FAIL reset_data: got rdata=%h addr=%h wd=%h expected 0", lsu_rdata, bus.d_addr, bus.d_wdata); end
      @(negedge clk);
      rst = 1'b0;
      exp_rdata = '0;
   endtask

   task automatic test_spec_cases();
      run_access(4'hB, 32'h100, 32'hDEADBEEF, 1'b1, 1, 32'h0);
      run_access(4'h1, 32'h103, 32'h0, 1'b1, 0, 32'h80123456);
      checks++;
      if (lsu_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_ext: got %h expected ffffff80", lsu_rdata); end
      run_access(4'h2, 32'h103, 32'h0, 1'b1, 0, 32'h80123456);
      checks++;
      if (lsu_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_ext: got %h expected 00000080", lsu_rdata); end
      run_access(4'h3, 32'h2, 32'h0, 1'b1, 2, 32'h80123456);
      checks++;
      if (lsu_rdata !== 32'hFFFF8012) begin errors++; $display("FAIL lh_ext: got %h expected ffff8012", lsu_rdata); end
      run_access(4'h4, 32'h2, 32'h0, 1'b0, 0, 32'h80123456);
      run_access(4'hA, 32'h102, 32'h00001234, 1'b1, 0, 32'h0);
      run_access(4'h9, 32'h101, 32'h000000A5, 1'b1, 3, 32'h0);
   endtask

   task automatic test_misaligned();
      run_access(4'h5, 32'h101, 32'h0, 1'b1, 0, 32'h0);
      run_access(4'hA, 32'h3, 32'h1234, 1'b1, 0, 32'h0);
      run_access(4'h3, 32'h5, 32'h0, 1'b1, 0, 32'h0);
      run_access(4'hB, 32'h102, 32'h0, 1'b1, 0, 32'h0);
   endtask

   task automatic test_timeout();
      run_access(4'h5, 32'h200, 32'h0, 1'b1, 0, 32'hCAFEF00D);
      run_access(4'h5, 32'h204, 32'h0, 1'b1, -1, 32'h0);
      checks++;
      if (lsu_rdata !== 32'h0) begin errors++; $display("FAIL timeout_rdata: got %h expected 0", lsu_rdata); end
      run_access(4'h5, 32'h208, 32'h0, 1'b1, TIMEOUT - 1, 32'h13579BDF);
      run_access(4'h1, 32'h20C, 32'h0, 1'b1, TIMEOUT, 32'hFFFFFFFF);
   endtask

   task automatic test_pass_through();
      for (int i = 0; i < 8; i++)
         run_access(4'hC + 4'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 1)), 0, 32'h0);
      run_access(4'h0, 32'h0, 32'h0, 1'b1, 0, 32'h0);
      run_access(4'h7, 32'h0, 32'h0, 1'b0, 0, 32'h0);
   endtask

   task automatic test_rst_mid_access();
      mem_op = 4'h5; mem_addr = 32'h40; mem_reg_wr = 1'b1;
      bus.d_ack = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++;
      if (bus.d_req !== 1'b1) begin errors++; $display("FAIL mid_req: got %b expected 1", bus.d_req); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.d_req, stall_req} !== 2'b00) begin errors++; $display("FAIL rst_drop: got d_req,stall=%b expected 00", {bus.d_req, stall_req}); end
      @(negedge clk);
      rst = 1'b0;
      mem_op = 4'h0;
      exp_rdata = '0;
      run_access(4'h5, 32'h44, 32'h0, 1'b1, 0, 32'h2468ACE0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 80; i++) begin
         int sel, ad;
         sel = $urandom_range(0, 9);
         if (sel < 7)      ad = $urandom_range(0, 3);
         else if (sel < 9) ad = $urandom_range(4, 17);
         else              ad = -1;
         run_access(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom_range(0, 1)), ad, $urandom);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_spec_cases();
      test_misaligned();
      test_timeout();
      test_pass_through();
      test_rst_mid_access();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
